// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared FFT framing defaults and the frame feeder state type
package mfcc_pkg;
  localparam int MFCC_NFFT = 512;
  localparam int MFCC_INPUT_WIDTH = 16;
  localparam int MFCC_FRAME_SIZE = 306;
  localparam int MFCC_HOP_SIZE = 153;
  typedef enum logic [1:0] {FILL, EMIT, START, WAIT_DONE} feeder_state_t;
endpackage

// File: rtl/sample_ring_ram.sv
// sample_ring_ram: simple dual-port sample ring, one write port and a registered read port
module sample_ring_ram #(
  parameter int DEPTH = 306,
  parameter int WIDTH = 16,
  parameter int AW = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers audio samples and emits overlapped zero-padded frames to the FFT
module fft_frame_feeder
  import mfcc_pkg::*;
#(
  parameter int NFFT = MFCC_NFFT,
  parameter int INPUT_WIDTH = MFCC_INPUT_WIDTH,
  parameter int FRAME_SIZE = MFCC_FRAME_SIZE,
  parameter int HOP_SIZE = MFCC_HOP_SIZE,
  localparam int PW = $clog2(NFFT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid_i,
  input  logic signed [INPUT_WIDTH-1:0] sample_i,
  output logic                          sample_ready_o,
  output logic                          fft_in_valid_o,
  output logic [PW-1:0]                 fft_frame_ptr_o,
  output logic signed [INPUT_WIDTH-1:0] fft_real_o,
  output logic                          fft_start_o,
  input  logic                          fft_done_i,
  output logic                          busy_o
);
  localparam int RW = FRAME_SIZE > 1 ? $clog2(FRAME_SIZE) : 1;
  localparam int CW = $clog2(FRAME_SIZE + 1);
  if (FRAME_SIZE > NFFT) begin : g_bad_frame
    $error("FRAME_SIZE must not exceed NFFT");
  end
  if (HOP_SIZE <= 0 || HOP_SIZE > FRAME_SIZE) begin : g_bad_hop
    $error("HOP_SIZE must satisfy 0 < HOP_SIZE <= FRAME_SIZE");
  end
  feeder_state_t state_q, state_d;
  logic [CW-1:0] new_cnt_q, cnt_inc, need;
  logic [RW-1:0] wr_ptr_q, wr_ptr_nxt, rd_ptr_q, rd_ptr_inc;
  logic [PW-1:0] idx_q, ptr_q;
  logic first_q, accept, go_emit, last_idx, valid_q, pad_q, start_q;
  logic [INPUT_WIDTH-1:0] rdata;
  always_comb begin
    need = first_q ? CW'(FRAME_SIZE) : CW'(HOP_SIZE);
    sample_ready_o = state_q == FILL ? new_cnt_q < need :
                     state_q == WAIT_DONE ? new_cnt_q < CW'(HOP_SIZE) : 1'b0;
    accept = sample_valid_i && sample_ready_o;
    cnt_inc = new_cnt_q + CW'(accept);
    wr_ptr_nxt = !accept ? wr_ptr_q : wr_ptr_q == RW'(FRAME_SIZE - 1) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_inc = rd_ptr_q == RW'(FRAME_SIZE - 1) ? '0 : rd_ptr_q + 1'b1;
    last_idx = idx_q == PW'(NFFT - 1);
    go_emit = (state_q == FILL && cnt_inc == need) ||
              (state_q == WAIT_DONE && fft_done_i && cnt_inc == CW'(HOP_SIZE));
    state_d = go_emit ? EMIT :
              state_q == EMIT && last_idx ? START :
              state_q == START ? WAIT_DONE :
              state_q == WAIT_DONE && fft_done_i ? FILL : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      new_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q <= '0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      ptr_q <= '0;
      pad_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      new_cnt_q <= go_emit ? '0 : cnt_inc;
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= go_emit ? wr_ptr_nxt : state_q == EMIT ? rd_ptr_inc : rd_ptr_q;
      idx_q <= state_q == EMIT && !last_idx ? idx_q + 1'b1 : '0;
      first_q <= first_q && !go_emit;
      valid_q <= state_q == EMIT;
      ptr_q <= idx_q;
      pad_q <= {1'b0, idx_q} >= (PW + 1)'(FRAME_SIZE);
      start_q <= state_q == START;
    end
  end
  sample_ring_ram #(.DEPTH(FRAME_SIZE), .WIDTH(INPUT_WIDTH), .AW(RW)) u_ram (
    .clk(clk),
    .we(accept),
    .waddr(wr_ptr_q),
    .wdata(sample_i),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  assign fft_in_valid_o = valid_q;
  assign fft_frame_ptr_o = ptr_q;
  assign fft_real_o = valid_q && !pad_q ? rdata : '0;
  assign fft_start_o = start_q;
  assign busy_o = state_q inside {EMIT, START, WAIT_DONE};
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: randomized scoreboard bench for the FFT frame feeder
module tb_fft_frame_feeder;
  import mfcc_pkg::*;
  localparam int NFFT = MFCC_NFFT;
  localparam int W = MFCC_INPUT_WIDTH;
  localparam int FS = MFCC_FRAME_SIZE;
  localparam int HOP = MFCC_HOP_SIZE;
  localparam int PW = $clog2(NFFT);
  logic clk = 1'b0, rst = 1'b1, sample_valid_i = 1'b0, fft_done_i = 1'b0;
  logic signed [W-1:0] sample_i = '0;
  logic sample_ready_o, fft_in_valid_o, fft_start_o, busy_o;
  logic [PW-1:0] fft_frame_ptr_o;
  logic signed [W-1:0] fft_real_o;
  fft_frame_feeder dut (
    .clk(clk),
    .rst(rst),
    .sample_valid_i(sample_valid_i),
    .sample_i(sample_i),
    .sample_ready_o(sample_ready_o),
    .fft_in_valid_o(fft_in_valid_o),
    .fft_frame_ptr_o(fft_frame_ptr_o),
    .fft_real_o(fft_real_o),
    .fft_start_o(fft_start_o),
    .fft_done_i(fft_done_i),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int c;
    int ptr;
    logic signed [W-1:0] re;
  } beat_t;
  beat_t exp_q[$];
  int start_q[$];
  int n_cmp = 0, n_bad = 0;
  logic signed [W-1:0] hist[$];
  logic signed [W-1:0] nxt = '0;
  int m_cnt = 0, m_need = FS, m_wait_at = 0, last_first = 0;
  bit m_busy = 0, rnd = 0;
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic flag(input string name, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected nothing (cycle %0d)", name, act, cyc);
  endtask
  function automatic bit model_ready();
    return m_busy ? (cyc >= m_wait_at && m_cnt < HOP) : (m_cnt < m_need);
  endfunction
  task automatic trigger();
    int sz;
    sz = hist.size();
    for (int k = 0; k < NFFT; k++) begin
      beat_t b;
      b.c = cyc + 2 + k;
      b.ptr = k;
      b.re = k < FS ? hist[sz - FS + k] : '0;
      exp_q.push_back(b);
    end
    start_q.push_back(cyc + 2 + NFFT);
    last_first = cyc + 2;
    m_wait_at = cyc + 2 + NFFT;
    m_cnt = 0;
    m_need = HOP;
    m_busy = 1;
  endtask
  task automatic step(input bit v, input bit d);
    bit pr;
    sample_valid_i = v;
    sample_i = nxt;
    fft_done_i = d;
    pr = model_ready();
    chk("ready", 32'(sample_ready_o), 32'(pr));
    chk("busy", 32'(busy_o), 32'(m_busy));
    if (v && pr) begin
      hist.push_back(nxt);
      m_cnt++;
      nxt = rnd ? W'($urandom) : nxt + 1'b1;
    end
    if (!m_busy && m_cnt == m_need) trigger();
    else if (m_busy && d && cyc >= m_wait_at) begin
      if (m_cnt == HOP) trigger();
      else m_busy = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sample_valid_i = 1'b0;
    fft_done_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
    hist.delete();
    m_cnt = 0;
    m_need = FS;
    m_busy = 0;
    chk("rst_ready", 32'(sample_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(fft_in_valid_o), 32'd0);
    chk("rst_start", 32'(fft_start_o), 32'd0);
    chk("rst_ptr", 32'(fft_frame_ptr_o), 32'd0);
    chk("rst_real", 32'(fft_real_o), 32'd0);
  endtask
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].c < cyc) begin
      flag("missed_beat_ptr", exp_q[0].ptr);
      void'(exp_q.pop_front());
    end
    while (start_q.size() != 0 && start_q[0] < cyc) begin
      flag("missed_start_cycle", start_q[0]);
      void'(start_q.pop_front());
    end
    if (fft_in_valid_o === 1'b1) begin
      if (exp_q.size() == 0) flag("unexpected_beat_ptr", 32'(fft_frame_ptr_o));
      else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_cycle", cyc, b.c);
        chk("beat_ptr", 32'(fft_frame_ptr_o), b.ptr);
        chk("beat_real", 32'(fft_real_o), 32'(b.re));
      end
    end
    if (fft_start_o === 1'b1) begin
      if (start_q.size() == 0) flag("unexpected_start", cyc);
      else chk("start_cycle", cyc, start_q.pop_front());
    end
  end
  initial begin
    bit v, d;
    int guard;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (FS) step(1, 0);
    while (cyc < m_wait_at) step(0, 0);
    step(0, 1);
    repeat (HOP) step(1, 0);
    while (cyc < m_wait_at + 200) step(1, 0);
    step(1, 1);
    rnd = 1;
    nxt = W'($urandom);
    d = 0;
    while (!d) begin
      v = ($urandom % 2) == 1;
      d = v && m_cnt == HOP - 1 && model_ready();
      step(v, d);
    end
    while (cyc < last_first + 100) step(($urandom % 2) == 1, ($urandom % 5) == 0);
    do_reset();
    while (hist.size() < FS - 1) step(($urandom % 4) != 0, ($urandom % 6) == 0);
    while (!m_busy) step(1, 0);
    while (cyc < last_first + 300) step(1, ($urandom % 4) == 0);
    repeat (5000) step(($urandom % 4) != 0, ($urandom % 30) == 0);
    guard = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && guard < 2000) begin
      step(0, 0);
      guard++;
    end
    if (exp_q.size() != 0 || start_q.size() != 0) flag("drain_timeout_pending", exp_q.size() + start_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
